// File: rtl/combo_pkg.sv
// rtl/combo_pkg.sv - press codes, combo sequences, ids and FSM states for combo_detector
package combo_pkg;

    localparam logic [1:0] CODE_LEFT  = 2'd0;
    localparam logic [1:0] CODE_RIGHT = 2'd1;
    localparam logic [1:0] CODE_DOWN  = 2'd2;
    localparam logic [1:0] CODE_PUNCH = 2'd3;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_1    = 2'd1;
    localparam logic [1:0] ID_2    = 2'd2;
    localparam logic [1:0] ID_3    = 2'd3;

    // Sequences are packed oldest-first, so the newest press sits in bits [1:0].
    localparam int         LEN_ID1 = 3;
    localparam int         LEN_ID2 = 4;
    localparam int         LEN_ID3 = 3;
    localparam logic [5:0] SEQ_ID1 = {CODE_DOWN, CODE_RIGHT, CODE_PUNCH};
    localparam logic [7:0] SEQ_ID2 = {CODE_RIGHT, CODE_DOWN, CODE_RIGHT, CODE_PUNCH};
    localparam logic [5:0] SEQ_ID3 = {CODE_DOWN, CODE_LEFT, CODE_PUNCH};

    localparam int HIST_DEPTH = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_COLLECT  = 2'd1;
    localparam state_t ST_FIRE     = 2'd2;
    localparam state_t ST_COOLDOWN = 2'd3;

    function automatic logic [1:0] encode_press(input logic [3:0] btn);
        logic [1:0] code;
        code = CODE_LEFT;
        case (btn)
            4'b0010: code = CODE_RIGHT;
            4'b0100: code = CODE_DOWN;
            4'b1000: code = CODE_PUNCH;
            default: code = CODE_LEFT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/combo_matcher.sv
// rtl/combo_matcher.sv - combinational match of the newest history entries against the combo table
module combo_matcher
    import combo_pkg::*;
(
    input  logic [7:0] hist,
    input  logic [2:0] depth,
    output logic       hit,
    output logic [1:0] id
);

    // Longest combo wins so that ID2 shadows ID1 when both end on the same press.
    always_comb begin
        hit = 1'b0;
        id  = ID_NONE;
        if (depth >= 3'(LEN_ID2) && hist == SEQ_ID2) begin
            hit = 1'b1;
            id  = ID_2;
        end else if (depth >= 3'(LEN_ID1) && hist[5:0] == SEQ_ID1) begin
            hit = 1'b1;
            id  = ID_1;
        end else if (depth >= 3'(LEN_ID3) && hist[5:0] == SEQ_ID3) begin
            hit = 1'b1;
            id  = ID_3;
        end
    end

endmodule

// File: rtl/combo_detector.sv
// rtl/combo_detector.sv - button-press combo recogniser with grace abort and post-fire cooldown
module combo_detector
    import combo_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 2_500_000,
    parameter int GRACE_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_pulse,
    input  logic       window_open,
    output logic       combo_valid,
    output logic [1:0] combo_id,
    output logic       cancel_out,
    output logic       busy,
    output logic [2:0] depth
);

    localparam int          CD_W      = 24;
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
    localparam int          GR_W      = $clog2(GRACE_CYCLES + 1);
    localparam logic [GR_W-1:0] GR_LAST = GR_W'(GRACE_CYCLES - 1);

    state_t          state;
    logic [7:0]      hist;
    logic [CD_W-1:0] cd_cnt;
    logic [GR_W-1:0] grace_cnt;

    logic       press_any;
    logic       press_valid;
    logic       press_invalid;
    logic [1:0] press_code;
    logic       base_clear;
    logic [7:0] push_hist;
    logic [2:0] push_depth;
    logic       match_hit;
    logic [1:0] match_id;

    assign press_any     = |btn_pulse;
    assign press_valid   = press_any && ((btn_pulse & (btn_pulse - 4'd1)) == 4'd0);
    assign press_invalid = press_any && !press_valid;
    assign press_code    = encode_press(btn_pulse);

    // A press outside an open window starts a fresh sequence; from IDLE the window
    // is not open yet, so the press always becomes the first entry.
    assign base_clear = (state == ST_IDLE) || !window_open;
    assign push_hist  = base_clear ? {6'd0, press_code} : {hist[5:0], press_code};
    assign push_depth = base_clear ? 3'd1 :
                        (depth == 3'(HIST_DEPTH)) ? 3'(HIST_DEPTH) : depth + 3'd1;

    combo_matcher u_matcher (
        .hist  (push_hist),
        .depth (push_depth),
        .hit   (match_hit),
        .id    (match_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hist        <= 8'd0;
            depth       <= 3'd0;
            cd_cnt      <= '0;
            grace_cnt   <= '0;
            combo_valid <= 1'b0;
            cancel_out  <= 1'b0;
            combo_id    <= ID_NONE;
            busy        <= 1'b0;
        end else begin
            combo_valid <= 1'b0;
            cancel_out  <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (press_invalid) begin
                        hist      <= 8'd0;
                        depth     <= 3'd0;
                        grace_cnt <= '0;
                        state     <= ST_IDLE;
                    end else if (press_valid) begin
                        hist      <= push_hist;
                        depth     <= push_depth;
                        grace_cnt <= '0;
                        if (match_hit) begin
                            combo_id    <= match_id;
                            combo_valid <= 1'b1;
                            cancel_out  <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ST_FIRE;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end else if (state == ST_COLLECT && !window_open) begin
                        if (grace_cnt == GR_LAST) begin
                            hist      <= 8'd0;
                            depth     <= 3'd0;
                            grace_cnt <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            grace_cnt <= grace_cnt + 1'b1;
                        end
                    end else begin
                        grace_cnt <= '0;
                    end
                end
                ST_FIRE: begin
                    hist   <= 8'd0;
                    depth  <= 3'd0;
                    cd_cnt <= '0;
                    state  <= ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (cd_cnt == CD_LAST) begin
                        cd_cnt <= '0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combo_detector.sv
// tb/tb_combo_detector.sv - directed self-checking bench for combo_detector
module tb_combo_detector;

    localparam logic [3:0] B_L = 4'b0001;
    localparam logic [3:0] B_R = 4'b0010;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_P = 4'b1000;
    localparam logic [3:0] B_0 = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_pulse = 4'd0;
    logic       window_open = 1'b0;
    logic       combo_valid;
    logic [1:0] combo_id;
    logic       cancel_out;
    logic       busy;
    logic [2:0] depth;

    int passed = 0;
    int total  = 0;
    int busy_cyc;
    int pulses;

    combo_detector #(.COOLDOWN_CYCLES(8), .GRACE_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_pulse   (btn_pulse),
        .window_open (window_open),
        .combo_valid (combo_valid),
        .combo_id    (combo_id),
        .cancel_out  (cancel_out),
        .busy        (busy),
        .depth       (depth)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Apply inputs for one cycle, then sample #1 after the capturing edge.
    task automatic step(input logic [3:0] b, input logic w);
        btn_pulse   = b;
        window_open = w;
        @(posedge clk);
        #1;
        btn_pulse = 4'd0;
    endtask

    // Counts busy cycles (including the current one) and further combo pulses until busy drops.
    task automatic drain(output int bcyc, output int npulse);
        bcyc   = busy ? 1 : 0;
        npulse = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            step(B_0, 1'b0);
            if (busy) bcyc++;
            if (combo_valid) npulse++;
        end
        if (busy) chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(combo_valid), 32'd0);
        chk("rst_cancel", 32'(cancel_out), 32'd0);
        chk("rst_id", 32'(combo_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        rst_n = 1'b1;

        // DOWN, RIGHT, PUNCH -> ID1, busy for FIRE + 8 cooldown cycles
        step(B_D, 1'b0);
        chk("t1_depth1", 32'(depth), 32'd1);
        step(B_R, 1'b1);
        chk("t1_depth2", 32'(depth), 32'd2);
        chk("t1_novalid", 32'(combo_valid), 32'd0);
        step(B_P, 1'b1);
        chk("t1_valid", 32'(combo_valid), 32'd1);
        chk("t1_cancel", 32'(cancel_out), 32'd1);
        chk("t1_id", 32'(combo_id), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        step(B_0, 1'b0);
        chk("t1_valid_drop", 32'(combo_valid), 32'd0);
        chk("t1_cancel_drop", 32'(cancel_out), 32'd0);
        chk("t1_depth_clr", 32'(depth), 32'd0);
        drain(busy_cyc, pulses);
        chk("t1_busy_cycles", 32'(busy_cyc + 1), 32'd9);
        chk("t1_extra_pulses", 32'(pulses), 32'd0);

        // RIGHT, DOWN, RIGHT, PUNCH -> ID2 has priority over ID1
        step(B_R, 1'b0);
        step(B_D, 1'b1);
        step(B_R, 1'b1);
        chk("t2_norm_early", 32'(combo_valid), 32'd0);
        step(B_P, 1'b1);
        chk("t2_valid", 32'(combo_valid), 32'd1);
        chk("t2_id", 32'(combo_id), 32'd2);
        drain(busy_cyc, pulses);

        // grace expiry: two closed-window cycles abort the sequence
        step(B_D, 1'b0);
        step(B_R, 1'b1);
        step(B_0, 1'b0);
        chk("t3_grace1_depth", 32'(depth), 32'd2);
        step(B_0, 1'b0);
        chk("t3_grace2_depth", 32'(depth), 32'd0);
        step(B_P, 1'b0);
        chk("t3_valid", 32'(combo_valid), 32'd0);
        chk("t3_depth", 32'(depth), 32'd1);
        step(B_0, 1'b0);
        chk("t3_valid_late", 32'(combo_valid), 32'd0);
        step(B_0, 1'b0);
        chk("t3_back_idle", 32'(depth), 32'd0);

        // multi-hot press clears the history
        step(B_D, 1'b0);
        step(4'b0011, 1'b1);
        chk("t4_invalid_depth", 32'(depth), 32'd0);
        step(B_R, 1'b0);
        step(B_P, 1'b1);
        chk("t4_valid", 32'(combo_valid), 32'd0);
        chk("t4_depth", 32'(depth), 32'd2);
        step(B_0, 1'b1);
        chk("t4_valid_late", 32'(combo_valid), 32'd0);
        step(4'b1111, 1'b1);
        chk("t4_clear", 32'(depth), 32'd0);

        // ID3 then a full ID1 sequence during cooldown is ignored
        step(B_D, 1'b0);
        step(B_L, 1'b1);
        step(B_P, 1'b1);
        chk("t5_valid", 32'(combo_valid), 32'd1);
        chk("t5_id", 32'(combo_id), 32'd3);
        step(B_D, 1'b1);
        step(B_R, 1'b1);
        step(B_P, 1'b1);
        chk("t5_cd_depth", 32'(depth), 32'd0);
        step(B_0, 1'b1);
        chk("t5_cd_valid", 32'(combo_valid), 32'd0);
        drain(busy_cyc, pulses);
        chk("t5_extra_pulses", 32'(pulses), 32'd0);
        chk("t5_id_held", 32'(combo_id), 32'd3);

        // reset during FIRE aborts immediately
        step(B_D, 1'b0);
        step(B_R, 1'b1);
        step(B_P, 1'b1);
        chk("t6_fire", 32'(combo_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(combo_valid), 32'd0);
        chk("t6_rst_cancel", 32'(cancel_out), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_depth", 32'(depth), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(B_0, 1'b0);
            if (combo_valid || busy) pulses++;
        end
        chk("t6_no_pulse", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/combo_detector.md
COMBO_DETECTOR -- requirements
Module: combo_detector

Interface
REQ-001 SHALL have parameter COOLDOWN_CYCLES, default 2_500_000, meaning the number of cycles inputs are ignored after a combo fires (legal range 1..2^24-1).
REQ-002 SHALL have parameter GRACE_CYCLES, default 2, meaning the number of consecutive window_open=0 cycles in COLLECT that abort a sequence.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn_pulse, input, 4 bits: single-cycle press pulses, with bit0=LEFT, bit1=RIGHT, bit2=DOWN, bit3=PUNCH.
REQ-006 SHALL have port window_open, input, 1 bit: the upstream combo-window status.
REQ-007 SHALL have port combo_valid, output, 1 bit: a 1-cycle pulse when a combo completes.
REQ-008 SHALL have port combo_id, output, 2 bits: the matched combo, held until the next fire (0 = none).
REQ-009 SHALL have port cancel_out, output, 1 bit: a 1-cycle pulse, coincident with combo_valid, that closes the upstream window.
REQ-010 SHALL have port busy, output, 1 bit: high during FIRE and COOLDOWN.
REQ-011 SHALL have port depth, output, 3 bits: the number of buffered presses (0..4).

Function
REQ-012 SHALL encode a press as a 2-bit code (LEFT=0, RIGHT=1, DOWN=2, PUNCH=3); a cycle with btn_pulse one-hot is a valid press, all-zero is no press, and multi-hot is an invalid press.
REQ-013 SHALL keep a 4-entry history shift register of codes plus depth; a push shifts in the newest code, increments depth saturating at 4, and drops the oldest entry at 4.
REQ-014 SHALL implement states IDLE, COLLECT, FIRE and COOLDOWN.
REQ-015 IDLE: a valid press SHALL push (depth becomes 1) and move to COLLECT regardless of window_open, because upstream opens its window one cycle after the press.
REQ-016 COLLECT: a valid press with window_open=1 SHALL push, and a valid press with window_open=0 SHALL clear the history, then push as the first entry.
REQ-017 COLLECT: window_open=0 with no press for GRACE_CYCLES consecutive cycles SHALL clear the history (depth=0) and move to IDLE; any press or window_open=1 resets the grace counter.
REQ-018 In any state, an invalid press SHALL clear the history and move to IDLE, except in FIRE and COOLDOWN, where it is ignored.
REQ-019 SHALL compare the post-push history (newest entry last) against the combos: ID2 = RIGHT,DOWN,RIGHT,PUNCH (4 entries); ID1 = DOWN,RIGHT,PUNCH (3); ID3 = DOWN,LEFT,PUNCH (3).
REQ-020 SHALL match only against the newest entries and require depth >= combo length; when several combos match, the priority is ID2 > ID1 > ID3.
REQ-021 On a match, SHALL latch combo_id and enter FIRE on the clock edge following the completing press, giving combo_valid a latency of 1 cycle from the press cycle.
REQ-022 FIRE: SHALL hold combo_valid=1 and cancel_out=1 for exactly 1 cycle, clear the history, and move to COOLDOWN.
REQ-023 COOLDOWN: SHALL ignore all presses, count COOLDOWN_CYCLES cycles, then move to IDLE; busy SHALL drop in the cycle IDLE is entered.
REQ-024 A press that completes no combo SHALL leave the state in COLLECT.
REQ-025 window_open SHALL be don't-care outside COLLECT.

Reset
REQ-026 While rst_n=0, SHALL force state=IDLE, history=0, depth=0, the grace and cooldown counters to 0, combo_valid=0, cancel_out=0, combo_id=0 and busy=0.
REQ-027 A reset asserted mid-FIRE or mid-COOLDOWN SHALL abort immediately with no further pulse.
REQ-028 After reset release, the first rising edge SHALL accept a press.

Structure
REQ-029 Shared package combo_pkg SHALL hold the press codes, the combo sequences and lengths, the combo IDs, and the state enumeration.
REQ-030 Matching SHALL live in one combinational sub-module combo_matcher (inputs: history and depth; outputs: hit and id).
REQ-031 All outputs SHALL be registered.

Verification (COOLDOWN_CYCLES=8, GRACE_CYCLES=2 on the bench)
REQ-032 SHALL cover: DOWN, RIGHT, PUNCH one cycle apart with window_open=1 from the cycle after the first press -> combo_valid=1 and cancel_out=1 exactly one cycle after PUNCH, combo_id=1, busy high for 9 cycles.
REQ-033 SHALL cover: RIGHT, DOWN, RIGHT, PUNCH -> combo_id=2 (not 1).
REQ-034 SHALL cover: DOWN, RIGHT, then window_open=0 for 2 cycles, then PUNCH -> no combo_valid, depth=1 after PUNCH.
REQ-035 SHALL cover: DOWN, then btn_pulse=4'b0011 (multi-hot), then RIGHT, PUNCH -> no fire, depth=2.
REQ-036 SHALL cover: DOWN, LEFT, PUNCH, then DOWN, RIGHT, PUNCH within cooldown -> one fire only, combo_id=3.
REQ-037 SHALL cover: rst_n low in the FIRE cycle -> combo_valid=0 and busy=0 immediately, with depth=0 after reset.
